// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the program-counter sequencer.
package pc_seq_pkg;
   localparam int LUT_IDX_W = 5;
   localparam int LUT_TGT_W = 8;
   localparam int CYC_W     = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2,
      S_HALT  = 2'd3
   } state_t;
endpackage

// File: rtl/pc_stall_timer.sv
// Countdown for the extra cycles a memory instruction occupies.
// Loaded with MEM_LAT-2 when the stall begins; zero marks the last stall cycle.
module pc_stall_timer #(
   parameter int MEM_LAT = 2
)(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);
   localparam int SW  = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
   localparam int LDV = (MEM_LAT > 2) ? MEM_LAT - 2 : 0;

   logic [SW-1:0] cnt;

   // load on stall entry, otherwise count down to zero and stay there
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  cnt <= '0;
      else if (load)               cnt <= SW'(LDV);
      else if (dec && cnt != '0)   cnt <= cnt - SW'(1);
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-path PC sequencer: run/halt handshake, branch via external target LUT,
// multi-cycle memory stall, watchdog and PC wrap detection.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              PCW      = 8,
   parameter logic [PCW-1:0]  START_PC = '0,
   parameter bit              REL_MODE = 1'b0,
   parameter int              MEM_LAT  = 2,
   parameter logic [CYC_W-1:0] MAX_CYC = 16'hFFFF
)(
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 Start,
   input  logic                 Halt,
   input  logic                 BrEn,
   input  logic                 BrTaken,
   input  logic [LUT_IDX_W-1:0] BrIdx,
   input  logic                 MemReq,
   output logic [LUT_IDX_W-1:0] LutAddr,
   input  logic [LUT_TGT_W-1:0] LutTarget,
   output logic [PCW-1:0]       PC,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Timeout,
   output logic                 Overflow,
   output logic [CYC_W-1:0]     CycleCnt
);
   localparam logic [CYC_W-1:0] WD_LIM = MAX_CYC - CYC_W'(1);

   state_t               state, state_n;
   logic [PCW-1:0]       pc_n;
   logic [CYC_W-1:0]     cnt_n;
   logic                 tmo_n, ovf_n;
   logic                 stall_load, stall_dec, stall_zero;
   logic [PCW:0]         pc_inc;
   logic [PCW+1:0]       rel_sum;

   // LUT index straight from the instruction field; result consumed same cycle
   assign LutAddr = BrIdx;
   assign Busy    = (state == S_RUN) || (state == S_STALL);
   assign Done    = (state == S_HALT);

   // extra top bit(s) catch wrap past the top and relative branches below zero
   assign pc_inc  = {1'b0, PC} + (PCW+1)'(1);
   assign rel_sum = {2'b00, PC} + (PCW+2)'($signed(LutTarget));

   pc_stall_timer #(.MEM_LAT(MEM_LAT)) u_stall (
      .clk   (Clk),
      .rst_n (Reset_n),
      .load  (stall_load),
      .dec   (stall_dec),
      .zero  (stall_zero)
   );

   // state, PC and status registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= S_IDLE;
         PC       <= START_PC;
         CycleCnt <= '0;
         Timeout  <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         state    <= state_n;
         PC       <= pc_n;
         CycleCnt <= cnt_n;
         Timeout  <= tmo_n;
         Overflow <= ovf_n;
      end
   end

   // next state, next PC, sticky flags and cycle counting
   always_comb begin
      state_n    = state;
      pc_n       = PC;
      cnt_n      = CycleCnt;
      tmo_n      = Timeout;
      ovf_n      = Overflow;
      stall_load = 1'b0;
      stall_dec  = 1'b0;
      if (Busy && CycleCnt != '1) cnt_n = CycleCnt + CYC_W'(1);
      case (state)
         S_IDLE: begin
            pc_n = START_PC;
            if (Start) begin
               state_n = S_RUN;
               cnt_n   = '0;
               tmo_n   = 1'b0;
               ovf_n   = 1'b0;
            end
         end
         S_RUN: begin
            if (Halt) begin
               state_n = S_HALT;
            end else if (CycleCnt == WD_LIM) begin
               state_n = S_HALT;
               tmo_n   = 1'b1;
            end else if (BrEn) begin
               // a branch wins over a simultaneous MemReq
               if (BrTaken) begin
                  if (REL_MODE) begin
                     pc_n = rel_sum[PCW-1:0];
                     if (rel_sum[PCW+1:PCW] != 2'b00) ovf_n = 1'b1;
                  end else begin
                     pc_n = PCW'(LutTarget);
                  end
               end else begin
                  pc_n = pc_inc[PCW-1:0];
                  if (pc_inc[PCW]) ovf_n = 1'b1;
               end
            end else if (MemReq && MEM_LAT > 1) begin
               state_n    = S_STALL;
               stall_load = 1'b1;
            end else begin
               pc_n = pc_inc[PCW-1:0];
               if (pc_inc[PCW]) ovf_n = 1'b1;
            end
         end
         S_STALL: begin
            // decoder inputs (including Halt) are ignored; the watchdog is not
            if (CycleCnt == WD_LIM) begin
               state_n = S_HALT;
               tmo_n   = 1'b1;
            end else if (stall_zero) begin
               state_n = S_RUN;
               pc_n    = pc_inc[PCW-1:0];
               if (pc_inc[PCW]) ovf_n = 1'b1;
            end else begin
               stall_dec = 1'b1;
            end
         end
         S_HALT: begin
            if (!Start) begin
               state_n = S_IDLE;
               pc_n    = START_PC;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: instance a is absolute/MEM_LAT=3/MAX_CYC=10, instance b is relative/defaults.
module tb_pc_sequencer;
   logic       Clk = 1'b0;
   logic       Reset_n, Start_a, Start_b, Halt, BrEn, BrTaken, MemReq;
   logic [4:0] BrIdx;
   logic [4:0] la_a, la_b;
   logic [7:0] lt_a, lt_b, pc_a, pc_b;
   logic       busy_a, done_a, tmo_a, ovf_a, busy_b, done_b, tmo_b, ovf_b;
   logic [15:0] cyc_a, cyc_b;
   int tests = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   // target LUT outside the sequencer
   function automatic logic [7:0] lut(input logic [4:0] a);
      case (a)
         5'd1:    lut = 8'h48;
         5'd2:    lut = 8'h10;
         5'd3:    lut = 8'h70;
         5'd4:    lut = 8'h00;
         5'd5:    lut = 8'hFC;
         5'd6:    lut = 8'hFF;
         5'd14:   lut = 8'h0E;
         5'd15:   lut = 8'h04;
         default: lut = 8'h01;
      endcase
   endfunction

   assign lt_a = lut(la_a);
   assign lt_b = lut(la_b);

   pc_sequencer #(.PCW(8), .START_PC(8'h00), .REL_MODE(1'b0), .MEM_LAT(3), .MAX_CYC(16'd10)) ua (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start_a), .Halt(Halt), .BrEn(BrEn), .BrTaken(BrTaken),
      .BrIdx(BrIdx), .MemReq(MemReq), .LutAddr(la_a), .LutTarget(lt_a), .PC(pc_a), .Busy(busy_a),
      .Done(done_a), .Timeout(tmo_a), .Overflow(ovf_a), .CycleCnt(cyc_a));

   pc_sequencer #(.PCW(8), .START_PC(8'h00), .REL_MODE(1'b1)) ub (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start_b), .Halt(Halt), .BrEn(BrEn), .BrTaken(BrTaken),
      .BrIdx(BrIdx), .MemReq(MemReq), .LutAddr(la_b), .LutTarget(lt_b), .PC(pc_b), .Busy(busy_b),
      .Done(done_b), .Timeout(tmo_b), .Overflow(ovf_b), .CycleCnt(cyc_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset_n = 1'b0; Start_a = 1'b0; Start_b = 1'b0; Halt = 1'b0;
      BrEn = 1'b0; BrTaken = 1'b0; MemReq = 1'b0; BrIdx = 5'd0;
      #12;
      chk("rst_pc", pc_a, 8'h00);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_tmo", tmo_a, 1'b0);
      chk("rst_ovf", ovf_a, 1'b0);
      chk("rst_cyc", cyc_a, 16'd0);
      Reset_n = 1'b1;

      // sequential run, halt at PC=5
      step(); Start_a = 1'b1;
      step(); chk("seq_pc0", pc_a, 8'h00); chk("seq_busy", busy_a, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         step(); chk("seq_pc", pc_a, i);
      end
      Halt = 1'b1;
      step(); Halt = 1'b0;
      chk("seq_done", done_a, 1'b1); chk("seq_pc5", pc_a, 8'h05);
      chk("seq_cyc", cyc_a, 16'd6); chk("seq_busy0", busy_a, 1'b0);
      step(); chk("seq_hold_done", done_a, 1'b1); chk("seq_hold_pc", pc_a, 8'h05);
      Start_a = 1'b0;
      step(); chk("seq_idle_done", done_a, 1'b0); chk("seq_idle_pc", pc_a, 8'h00);

      // absolute branches
      Start_a = 1'b1;
      step(); step(); step(); step();
      chk("abs_pc3", pc_a, 8'h03);
      BrEn = 1'b1; BrTaken = 1'b1; BrIdx = 5'd1; #1;
      chk("lut_addr", la_a, 5'd1);
      step(); chk("abs_taken", pc_a, 8'h48);
      BrTaken = 1'b0;
      step(); chk("abs_not_taken", pc_a, 8'h49);
      BrTaken = 1'b1; BrIdx = 5'd16;
      step(); chk("abs_default", pc_a, 8'h01);
      BrIdx = 5'd1; MemReq = 1'b1;
      step(); chk("br_mem_pc", pc_a, 8'h48);
      BrEn = 1'b0; BrTaken = 1'b0; MemReq = 1'b0;
      step(); chk("br_mem_nostall", pc_a, 8'h49);
      Halt = 1'b1;
      step(); Halt = 1'b0; Start_a = 1'b0;
      chk("abs_cyc", cyc_a, 16'd9); chk("abs_tmo", tmo_a, 1'b0);
      step();

      // memory stall, MEM_LAT=3
      Start_a = 1'b1;
      step(); step(); step();
      chk("mem_pc2", pc_a, 8'h02);
      MemReq = 1'b1;
      step(); MemReq = 1'b0; BrEn = 1'b1; BrTaken = 1'b1; BrIdx = 5'd1; Halt = 1'b1;
      chk("stall1_pc", pc_a, 8'h02); chk("stall1_busy", busy_a, 1'b1);
      step(); chk("stall2_pc", pc_a, 8'h02); chk("stall2_busy", busy_a, 1'b1);
      BrEn = 1'b0; BrTaken = 1'b0; Halt = 1'b0;
      step(); chk("stall_exit_pc", pc_a, 8'h03); chk("stall_exit_done", done_a, 1'b0);
      chk("stall_cyc", cyc_a, 16'd5);

      // reset in the middle of a stall
      MemReq = 1'b1;
      step(); MemReq = 1'b0;
      step();
      chk("mid_stall_busy", busy_a, 1'b1);
      Reset_n = 1'b0; #1;
      chk("rst_mid_pc", pc_a, 8'h00); chk("rst_mid_busy", busy_a, 1'b0);
      chk("rst_mid_cyc", cyc_a, 16'd0);
      #3; Reset_n = 1'b1;
      step(); chk("resume_pc0", pc_a, 8'h00); chk("resume_busy", busy_a, 1'b1);
      step(); chk("resume_pc1", pc_a, 8'h01);
      Halt = 1'b1;
      step(); Halt = 1'b0; Start_a = 1'b0;
      step();

      // watchdog on a branch-to-self loop
      Start_a = 1'b1; BrEn = 1'b1; BrTaken = 1'b1; BrIdx = 5'd4;
      step();
      for (int i = 0; i < 9; i++) step();
      chk("wd_pre_busy", busy_a, 1'b1); chk("wd_pre_cyc", cyc_a, 16'd9);
      step();
      chk("wd_done", done_a, 1'b1); chk("wd_tmo", tmo_a, 1'b1);
      chk("wd_cyc", cyc_a, 16'd10); chk("wd_pc", pc_a, 8'h00);
      Start_a = 1'b0; BrEn = 1'b0; BrTaken = 1'b0;
      step(); chk("wd_sticky", tmo_a, 1'b1);
      Start_a = 1'b1;
      step(); chk("wd_clear_tmo", tmo_a, 1'b0); chk("wd_clear_cyc", cyc_a, 16'd0);

      // sequential wrap in absolute mode
      BrEn = 1'b1; BrTaken = 1'b1; BrIdx = 5'd6;
      step(); chk("wrap_pcff", pc_a, 8'hFF); chk("wrap_ovf0", ovf_a, 1'b0);
      BrEn = 1'b0; BrTaken = 1'b0;
      step(); chk("wrap_pc0", pc_a, 8'h00); chk("wrap_ovf1", ovf_a, 1'b1);
      Halt = 1'b1;
      step(); Halt = 1'b0; Start_a = 1'b0;
      step();

      // relative branches on instance b
      Start_b = 1'b1; BrEn = 1'b1; BrTaken = 1'b1; BrIdx = 5'd2;
      step(); chk("rel_pc0", pc_b, 8'h00);
      step(); chk("rel_pc10", pc_b, 8'h10);
      BrIdx = 5'd14;
      step(); chk("rel_pc1e", pc_b, 8'h1E);
      BrIdx = 5'd3;
      step(); step(); chk("rel_pcfe", pc_b, 8'hFE); chk("rel_ovf0", ovf_b, 1'b0);
      BrIdx = 5'd15;
      step(); chk("rel_wrap_pc", pc_b, 8'h02); chk("rel_wrap_ovf", ovf_b, 1'b1);
      BrTaken = 1'b0;
      step(); chk("rel_not_taken", pc_b, 8'h03);
      BrEn = 1'b0; MemReq = 1'b1;
      step(); MemReq = 1'b0;
      chk("rel_stall_pc", pc_b, 8'h03); chk("rel_stall_busy", busy_b, 1'b1);
      step(); chk("rel_stall_exit", pc_b, 8'h04);
      Halt = 1'b1;
      step(); Halt = 1'b0; Start_b = 1'b0;
      chk("rel_done", done_b, 1'b1);
      step();
      Start_b = 1'b1;
      step(); chk("rel_ovf_clear", ovf_b, 1'b0);
      BrEn = 1'b1; BrTaken = 1'b1; BrIdx = 5'd5;
      step(); chk("rel_neg_pc", pc_b, 8'hFC); chk("rel_neg_ovf", ovf_b, 1'b1);
      BrEn = 1'b0; BrTaken = 1'b0; Halt = 1'b1;
      step(); Halt = 1'b0; Start_b = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the core's fetch path.
- Owns the PC and the run/halt handshake with the testbench/top level.
- Selects PC+1, a branch target, or hold each cycle.
- Drives the 5-bit index of the branch-target lookup table (combinational, Target = f(Addr), 8-bit target) and consumes its result, in absolute or PC-relative mode.
- Adds multi-cycle stall for memory ops, a watchdog, and wrap detection.

Parameters:
PCW, 8, PC width in bits (>= 8).
START_PC, 0, PC value loaded in IDLE.
REL_MODE, 0, 0 = target is absolute PC; 1 = target is signed 8-bit offset added to PC.
MEM_LAT, 2, total cycles a memory instruction occupies (>= 1).
MAX_CYC, 16'hFFFF, watchdog limit on executed cycles.

Ports:
Clk  in  1  system clock, rising edge.
Reset_n  in  1  asynchronous, active-low reset.
Start  in  1  level request to run a program.
Halt  in  1  decoded halt instruction at current PC.
BrEn  in  1  current instruction is a branch.
BrTaken  in  1  branch condition true (valid with BrEn).
BrIdx  in  5  LUT index from instruction field.
MemReq  in  1  current instruction is load/store.
LutAddr  out  5  index to target LUT.
LutTarget  in  8  LUT result.
PC  out  PCW  current program counter.
Busy  out  1  high in RUN or STALL.
Done  out  1  high in HALT.
Timeout  out  1  sticky; HALT entered via watchdog.
Overflow  out  1  sticky; PC wrapped modulo 2^PCW.
CycleCnt  out  16  cycles spent in RUN+STALL for current program.

Behaviour:
- Reset (async, Reset_n=0): state IDLE, PC=START_PC, Busy=0, Done=0, Timeout=0, Overflow=0, CycleCnt=0. Takes effect immediately, including mid-program or mid-stall. Stall counter cleared.
- LutAddr = BrIdx combinationally at all times. No latency; LUT result is used in the same cycle.
- States:
  - IDLE: PC held at START_PC. Start=1 at an edge -> RUN. On that edge CycleCnt, Timeout and Overflow clear. PC stays START_PC, so the first RUN cycle fetches START_PC.
  - RUN: evaluated each edge, priority Halt > watchdog > BrEn > MemReq > sequential.
    - Halt=1: -> HALT, PC held.
    - CycleCnt == MAX_CYC-1: -> HALT, Timeout=1, PC held.
    - BrEn & BrTaken: PC = LutTarget zero-extended (REL_MODE=0), or PC + sign-extended LutTarget modulo 2^PCW (REL_MODE=1).
    - BrEn & !BrTaken: PC+1.
    - MemReq (MEM_LAT>1): -> STALL, PC held, stall counter = MEM_LAT-2.
    - MemReq (MEM_LAT=1): treated as sequential.
    - Otherwise: PC+1.
  - STALL: PC held; decoder inputs ignored. At stall counter==0: PC+1, -> RUN. Otherwise decrement.
    - A memory op therefore spans exactly MEM_LAT cycles.
    - Halt is not sampled in STALL; the watchdog is.
  - HALT: Done=1, PC frozen. Start=0 at an edge -> IDLE (Done drops, PC=START_PC). Start held high keeps HALT.
- CycleCnt increments every edge in RUN or STALL and saturates at 16'hFFFF.
- Overflow: set when any PC update wraps past 2^PCW-1 to 0 (sequential or relative), or when a relative branch goes below 0. Sticky until reset or next start.
- BrEn with MemReq in the same cycle is illegal encoding. The branch wins and MemReq is ignored.
- Start deasserting during RUN/STALL has no effect. A program runs until Halt or watchdog.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum (IDLE, RUN, STALL, HALT), 2-bit.
  - LUT_IDX_W=5 and LUT_TGT_W=8.
  - CYC_W=16.
- The LUT stays a separate instance at top level, wired through LutAddr/LutTarget.
- One natural sub-module: pc_stall_timer. It loads MEM_LAT-2 and counts down to zero, with async active-low reset.
- The FSM and PC update logic stay in pc_sequencer.

Test Plan:
- Reset mid-STALL (MEM_LAT=3, Reset_n low for half a cycle) -> PC=START_PC, Busy=0 immediately, IDLE next; Start=1 resumes from 0.
- Start=1, no branches, Halt at PC=5 -> PC 0,1,2,3,4,5 then Done=1, CycleCnt=6, PC stays 5; Start=0 -> IDLE, PC=0.
- REL_MODE=0, PC=3, BrEn=1, BrTaken=1, BrIdx=1 (LUT 8'h48) -> next PC=8'h48. Same with BrTaken=0 -> PC=4. BrIdx=16 (LUT default 1) -> PC=1.
- REL_MODE=1, PC=8'h10, BrIdx=14 (8'h0E) -> PC=8'h1E. PC=8'hFE, BrIdx=15 (8'h04) -> PC=8'h02, Overflow=1.
- MEM_LAT=3, MemReq at PC=2 -> PC held 3 cycles (Busy=1, BrEn ignored), then PC=3.
- MAX_CYC=10, branch loop to self -> HALT after 10 cycles, Timeout=1, Done=1, CycleCnt=10.
